// File: rtl/shift_reg_engine_pkg.sv
// Shared types and opcode helpers for the parametrised shift/rotate engine.
package shift_reg_engine_pkg;

  typedef enum logic [2:0] {
    OpNop   = 3'd0,
    OpLoad  = 3'd1,
    OpShl   = 3'd2,
    OpShr   = 3'd3,
    OpRol   = 3'd4,
    OpRor   = 3'd5,
    OpAsr   = 3'd6,
    OpClear = 3'd7
  } shift_op_e;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StShift = 1'b1
  } shift_state_e;

  function automatic logic is_rotate(shift_op_e op);
    return op inside {OpRol, OpRor};
  endfunction

  function automatic logic is_shift(shift_op_e op);
    return op inside {OpShl, OpShr, OpRol, OpRor, OpAsr};
  endfunction

endpackage

// File: rtl/shift_reg_engine_if.sv
// Command handshake and data bus of the shift engine.
interface shift_reg_engine_if #(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned AMT_W = $clog2(WIDTH + 1);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [AMT_W-1:0] cmd_amt;
  logic             cmd_fill;
  logic [WIDTH-1:0] d_in;
  logic [WIDTH-1:0] d_out;
  logic             busy;
  logic             done;

  modport master (
    output cmd_valid, cmd_op, cmd_amt, cmd_fill, d_in,
    input  cmd_ready, d_out, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_amt, cmd_fill, d_in,
    output cmd_ready, d_out, busy, done
  );
endinterface

// File: rtl/shift_reg_engine_step_unit.sv
// Combinational single-step shifter: moves data by s bits (0..STEP) for the given op.
module shift_step_unit
  import shift_reg_engine_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AMT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] data,
  input  shift_op_e        op,
  input  logic             fill,
  input  logic [AMT_W-1:0] s,
  output logic [WIDTH-1:0] result
);
  localparam logic [WIDTH-1:0] Ones = '1;

  // Rotates never see s == WIDTH, so s_inv stays in 1..WIDTH and s == 0 wraps nothing.
  logic [AMT_W-1:0] s_inv;
  assign s_inv = AMT_W'(WIDTH) - s;

  always_comb begin
    result = data;
    case (op)
      OpShl:   result = (data << s) | ({WIDTH{fill}} & ~(Ones << s));
      OpShr:   result = (data >> s) | ({WIDTH{fill}} & ~(Ones >> s));
      OpRol:   result = (data << s) | (data >> s_inv);
      OpRor:   result = (data >> s) | (data << s_inv);
      OpAsr:   result = $unsigned($signed(data) >>> s);
      default: result = data;
    endcase
  end
endmodule

// File: rtl/shift_reg_engine.sv
// Multi-cycle shift/rotate register with valid/ready command handshake and done pulse.
module shift_reg_engine
  import shift_reg_engine_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned STEP  = 1
) (
  input logic              clk,
  input logic              reset,
  shift_reg_engine_if.slave bus
);
  localparam int unsigned      AMT_W    = $clog2(WIDTH + 1);
  localparam logic [AMT_W-1:0] WidthAmt = AMT_W'(WIDTH);
  localparam logic [AMT_W-1:0] StepAmt  = AMT_W'(STEP);

  shift_state_e     state_q, state_d;
  shift_op_e        op_q, op_d, cmd_op;
  logic [WIDTH-1:0] data_q, data_d, step_data;
  logic [AMT_W-1:0] rem_q, rem_d, amt_eff, step_amt;
  logic             fill_q, fill_d;
  logic             done_q, done_d;

  assign cmd_op = shift_op_e'(bus.cmd_op);

  // Logical/arithmetic shifts saturate at WIDTH; rotates wrap modulo WIDTH.
  always_comb begin
    if (is_rotate(cmd_op)) begin
      amt_eff = bus.cmd_amt % WidthAmt;
    end else begin
      amt_eff = (bus.cmd_amt > WidthAmt) ? WidthAmt : bus.cmd_amt;
    end
  end

  assign step_amt = (rem_q > StepAmt) ? StepAmt : rem_q;

  shift_step_unit #(
    .WIDTH (WIDTH),
    .AMT_W (AMT_W)
  ) u_step (
    .data   (data_q),
    .op     (op_q),
    .fill   (fill_q),
    .s      (step_amt),
    .result (step_data)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    rem_d   = rem_q;
    fill_d  = fill_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.cmd_valid) begin
          op_d   = cmd_op;
          fill_d = bus.cmd_fill;
          if (is_shift(cmd_op) && (amt_eff != '0)) begin
            state_d = StShift;
            rem_d   = amt_eff;
          end else begin
            done_d = 1'b1;
            if (cmd_op == OpLoad) begin
              data_d = bus.d_in;
            end else if (cmd_op == OpClear) begin
              data_d = '0;
            end
          end
        end
      end
      StShift: begin
        data_d = step_data;
        rem_d  = rem_q - step_amt;
        if (rem_q == step_amt) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      op_q    <= OpNop;
      data_q  <= '0;
      rem_q   <= '0;
      fill_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      fill_q  <= fill_d;
      done_q  <= done_d;
    end
  end

  assign bus.cmd_ready = (state_q == StIdle);
  assign bus.busy      = (state_q == StShift);
  assign bus.done      = done_q;
  assign bus.d_out     = data_q;
endmodule

// File: tb/tb_shift_reg_engine.sv
// Self-checking bench: two engine instances (8-bit/step 1, 16-bit/step 4) against a bitwise model.
module tb_shift_reg_engine;
  logic clk = 1'b0;
  logic reset_a, reset_b;
  always #5 clk = ~clk;

  shift_reg_engine_if #(.WIDTH(8))  bus_a ();
  shift_reg_engine_if #(.WIDTH(16)) bus_b ();

  shift_reg_engine #(.WIDTH(8), .STEP(1)) dut_a (.clk(clk), .reset(reset_a), .bus(bus_a));
  shift_reg_engine #(.WIDTH(16), .STEP(4)) dut_b (.clk(clk), .reset(reset_b), .bus(bus_b));

  int errors = 0;
  int checks = 0;
  int wid[2]  = '{8, 16};
  int step[2] = '{1, 4};
  logic [15:0] mdl[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d, input bit v, input int op, input int amt, input bit fill,
                       input logic [15:0] din);
    if (d == 0) begin
      bus_a.cmd_valid = v;
      bus_a.cmd_op    = 3'(op);
      bus_a.cmd_amt   = 4'(amt);
      bus_a.cmd_fill  = fill;
      bus_a.d_in      = din[7:0];
    end else begin
      bus_b.cmd_valid = v;
      bus_b.cmd_op    = 3'(op);
      bus_b.cmd_amt   = 5'(amt);
      bus_b.cmd_fill  = fill;
      bus_b.d_in      = din;
    end
  endtask

  // which: 0 d_out, 1 busy, 2 done, 3 cmd_ready
  function automatic logic [31:0] obs(input int d, input int which);
    if (d == 0) begin
      case (which)
        0: return 32'(bus_a.d_out);
        1: return 32'(bus_a.busy);
        2: return 32'(bus_a.done);
        default: return 32'(bus_a.cmd_ready);
      endcase
    end else begin
      case (which)
        0: return 32'(bus_b.d_out);
        1: return 32'(bus_b.busy);
        2: return 32'(bus_b.done);
        default: return 32'(bus_b.cmd_ready);
      endcase
    end
  endfunction

  // Whole-command reference: applies the effective amount one bit at a time.
  function automatic logic [15:0] ref_op(input int w, input int op, input int amt, input bit fill,
                                         input logic [15:0] cur, input logic [15:0] din,
                                         output int n);
    logic [31:0] v, mask, msb, lsb;
    mask = (32'd1 << w) - 1;
    v    = 32'(cur);
    n    = 0;
    case (op)
      1: return 16'(32'(din) & mask);
      7: return 16'd0;
      2, 3, 6: n = (amt > w) ? w : amt;
      4, 5: n = amt % w;
      default: n = 0;
    endcase
    for (int i = 0; i < n; i++) begin
      msb = (v >> (w - 1)) & 1;
      lsb = v & 1;
      case (op)
        2: v = ((v << 1) | 32'(fill)) & mask;
        3: v = (v >> 1) | (32'(fill) << (w - 1));
        4: v = ((v << 1) | msb) & mask;
        5: v = (v >> 1) | (lsb << (w - 1));
        default: v = (v >> 1) | (msb << (w - 1));
      endcase
    end
    return 16'(v);
  endfunction

  task automatic run_cmd(input int d, input int op, input int amt, input bit fill,
                         input logic [15:0] din, input string tag);
    int n, exp_cyc, cyc;
    logic [15:0] exp;
    chk({tag, "_ready"}, obs(d, 3), 32'd1);
    exp     = ref_op(wid[d], op, amt, fill, mdl[d], din, n);
    exp_cyc = (n == 0) ? 0 : (n + step[d] - 1) / step[d];
    drive(d, 1'b1, op, amt, fill, din);
    tick;
    drive(d, 1'b0, 0, 0, 1'b0, 16'h0);
    cyc = 0;
    while (obs(d, 1) == 32'd1 && cyc < 64) begin
      cyc++;
      tick;
    end
    chk({tag, "_busy_cycles"}, 32'(cyc), 32'(exp_cyc));
    chk({tag, "_done"}, obs(d, 2), 32'd1);
    chk({tag, "_dout"}, obs(d, 0), 32'(exp));
    mdl[d] = exp;
    tick;
    chk({tag, "_done_single"}, obs(d, 2), 32'd0);
  endtask

  initial begin
    int dn;
    reset_a = 1'b1;
    reset_b = 1'b1;
    drive(0, 1'b0, 0, 0, 1'b0, 16'h0);
    drive(1, 1'b0, 0, 0, 1'b0, 16'h0);
    tick;
    tick;
    reset_a = 1'b0;
    reset_b = 1'b0;
    mdl[0] = '0;
    mdl[1] = '0;
    chk("rst_dout", obs(0, 0), 32'h0);
    chk("rst_busy", obs(0, 1), 32'h0);
    chk("rst_done", obs(0, 2), 32'h0);
    chk("rst_ready", obs(0, 3), 32'h1);
    chk("rst_dout_b", obs(1, 0), 32'h0);

    // 8-bit, step 1 directed cases
    run_cmd(0, 1, 0, 1'b0, 16'hA5, "load_a5");
    run_cmd(0, 3, 3, 1'b1, 16'h0, "shr3_f1");
    chk("shr3_f1_lit", obs(0, 0), 32'hF4);
    run_cmd(0, 1, 0, 1'b0, 16'hA5, "load_a5b");
    run_cmd(0, 2, 2, 1'b0, 16'h0, "shl2");
    chk("shl2_lit", obs(0, 0), 32'h94);
    run_cmd(0, 4, 12, 1'b0, 16'h0, "rol12");
    chk("rol12_lit", obs(0, 0), 32'h49);
    run_cmd(0, 1, 0, 1'b0, 16'h96, "load_96");
    run_cmd(0, 6, 3, 1'b0, 16'h0, "asr3");
    chk("asr3_lit", obs(0, 0), 32'hF2);
    run_cmd(0, 3, 9, 1'b0, 16'h0, "shr9_sat");
    chk("shr9_lit", obs(0, 0), 32'h00);
    run_cmd(0, 1, 0, 1'b0, 16'h5A, "load_5a");
    run_cmd(0, 2, 0, 1'b1, 16'h0, "shl0");
    chk("shl0_lit", obs(0, 0), 32'h5A);

    // 16-bit, step 4
    run_cmd(1, 1, 0, 1'b0, 16'hBEEF, "b_load");
    run_cmd(1, 3, 9, 1'b0, 16'h0, "b_shr9");
    chk("b_shr9_lit", obs(1, 0), 32'h005F);

    // LOAD held valid during a shift is ignored until the done cycle
    run_cmd(0, 1, 0, 1'b0, 16'hA5, "hs_load");
    drive(0, 1'b1, 3, 3, 1'b1, 16'h0);
    tick;
    drive(0, 1'b1, 1, 0, 1'b0, 16'h3C);
    chk("hs_ready_low", obs(0, 3), 32'h0);
    chk("hs_busy", obs(0, 1), 32'h1);
    tick;
    chk("hs_ready_low2", obs(0, 3), 32'h0);
    tick;
    tick;
    chk("hs_done", obs(0, 2), 32'h1);
    chk("hs_dout_shift", obs(0, 0), 32'hF4);
    chk("hs_ready_back", obs(0, 3), 32'h1);
    tick;
    drive(0, 1'b0, 0, 0, 1'b0, 16'h0);
    chk("hs_load_taken", obs(0, 0), 32'h3C);
    chk("hs_load_done", obs(0, 2), 32'h1);
    tick;
    chk("hs_done_low", obs(0, 2), 32'h0);
    mdl[0] = 16'h3C;

    // Back-to-back LOAD, LOAD, CLEAR
    dn = 0;
    drive(0, 1'b1, 1, 0, 1'b0, 16'h11);
    tick;
    dn += int'(obs(0, 2));
    chk("b2b_load1", obs(0, 0), 32'h11);
    drive(0, 1'b1, 1, 0, 1'b0, 16'h22);
    tick;
    dn += int'(obs(0, 2));
    chk("b2b_load2", obs(0, 0), 32'h22);
    drive(0, 1'b1, 7, 0, 1'b0, 16'h0);
    tick;
    dn += int'(obs(0, 2));
    drive(0, 1'b0, 0, 0, 1'b0, 16'h0);
    chk("b2b_clear", obs(0, 0), 32'h0);
    chk("b2b_pulses", 32'(dn), 32'd3);
    tick;
    chk("b2b_done_low", obs(0, 2), 32'h0);
    mdl[0] = '0;

    // Reset in the 2nd cycle of ROR 5
    run_cmd(0, 1, 0, 1'b0, 16'hA5, "rr_load");
    drive(0, 1'b1, 5, 5, 1'b0, 16'h0);
    tick;
    drive(0, 1'b0, 0, 0, 1'b0, 16'h0);
    tick;
    reset_a = 1'b1;
    tick;
    reset_a = 1'b0;
    chk("rr_dout", obs(0, 0), 32'h0);
    chk("rr_busy", obs(0, 1), 32'h0);
    chk("rr_done", obs(0, 2), 32'h0);
    chk("rr_ready", obs(0, 3), 32'h1);
    dn = 0;
    for (int i = 0; i < 8; i++) begin
      tick;
      dn += int'(obs(0, 2));
    end
    chk("rr_no_done", 32'(dn), 32'd0);
    mdl[0] = '0;

    // Randomised commands on both instances
    for (int i = 0; i < 24; i++) begin
      run_cmd(0, int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)), 16'($urandom), "rnd_a");
      run_cmd(1, int'($urandom_range(0, 7)), int'($urandom_range(0, 31)),
              1'($urandom_range(0, 1)), 16'($urandom), "rnd_b");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
